serial_adder: RTL
=================

# serial_adder

Bit-serial ripple adder built around the single-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in on a start pulse and feeds one bit pair per clock, LSB first, into a full adder. The carry-out is registered and returned as the next cycle's carry-in. After WIDTH cycles it presents the registered WIDTH-bit sum and final carry-out with a one-cycle done pulse. It sits directly upstream of the full-adder cell, sequences its inputs, and consumes its sum/cout outputs.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only when not busy.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on.
- sum  output  WIDTH  result (a + b + cin) mod 2^WIDTH; registered.
- cout  output  1  carry out of bit WIDTH-1; registered.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: on clock edge with start=1:
  - load a and b into shift registers sa and sb;
  - carry register c <= cin;
  - bit counter cnt <= 0;
  - go to RUN.
- RUN, each edge:
  - full adder computes s = sa[0]^sb[0]^c and co = majority(sa[0],sb[0],c);
  - sa and sb shift right by one;
  - s shifts into the MSB of the accumulator acc;
  - c <= co;
  - cnt <= cnt+1.
  - On the edge where cnt = WIDTH-1: sum <= final acc (including this bit), cout <= co, go to DONE.
- DONE: lasts one cycle, done=1.
  - start=1 in DONE is accepted exactly as in IDLE: operands load and the FSM goes to RUN.
  - Otherwise the FSM goes to IDLE.
- busy = (state == RUN). done = (state == DONE).
- sum and cout change only on the completing edge or on reset. They hold their value through IDLE and through the entire next operation.
- start in RUN is ignored. Operands are not re-sampled, and a, b and cin may change freely after the accepted start.
- The counter is sized to hold WIDTH-1. No arithmetic wider than 1 bit is performed outside the full adder.

## Timing
- Reset (any state, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, c=0, cnt=0.
  - An aborted operation produces no done pulse and leaves sum=0.
  - rst takes priority over start on the same edge.
- Latency, with start sampled at edge E0:
  - busy=1 after E0;
  - bits 0..WIDTH-1 are processed at edges E1..E(WIDTH);
  - after E(WIDTH): busy=0, done=1, sum/cout valid;
  - done drops after E(WIDTH+1).
  - Start-to-done is WIDTH+1 edges (9 for WIDTH=8).
- Throughput:
  - with start held or re-asserted in DONE: one result every WIDTH+1 cycles;
  - otherwise, from IDLE: one result every WIDTH+2 cycles.
- Outputs are registered. No combinational path exists from any input to any output.

## Test plan
- WIDTH=8. Start with a=8'h00, b=8'h00, cin=0 -> busy high for 8 cycles; done pulses 9 cycles after the start edge; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0.
- a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1 (carry ripples through all 8 bits).
- Accepted start with a=8'h12, b=8'h34, cin=0:
  - re-pulse start with different operands at cycle 3 -> ignored; result sum=8'h46, cout=0.
  - change a and b on the cycle after start -> result unaffected.
- After a completed add (sum=8'h46), start a=8'hF0, b=8'h0F, cin=1, then assert rst at cycle 4 -> next cycle busy=0, done=0, sum=8'h00, cout=0; no done pulse follows.
- Hold start=1 continuously with a=8'h01, b=8'h01, cin=0 -> done pulses every 9 cycles, each with sum=8'h02; sum stays 8'h02 during the RUN phases between them.

Source files
------------

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and the bit-serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic             cin;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    modport master(output start, a, b, cin, input busy, done, sum, cout);
    modport slave(input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder feeding one bit pair per clock through a full adder
module serial_adder #(parameter int WIDTH = 8) (
    input logic          clk,
    input logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] sa, sb, acc, sum;
    logic [CW-1:0]    cnt;
    logic             c, s, co, load, last, cout;
    always_comb begin
        s    = sa[0] ^ sb[0] ^ c;
        co   = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        load = bus.start && state != RUN;
        last = state == RUN && cnt == CW'(WIDTH - 1);
        nxt  = load ? RUN : last ? DONE : state == DONE ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= nxt;
            if (load) begin
                sa  <= bus.a;
                sb  <= bus.b;
                c   <= bus.cin;
                cnt <= '0;
            end else if (state == RUN) begin
                sa  <= sa >> 1;
                sb  <= sb >> 1;
                acc <= {s, acc[WIDTH-1:1]};
                c   <= co;
                cnt <= cnt + CW'(1);
            end
            // the final bit is folded straight into the result, not via acc
            if (last) begin
                sum  <= {s, acc[WIDTH-1:1]};
                cout <= co;
            end
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.sum  = sum;
    assign bus.cout = cout;
endmodule
